// File: rtl/dw_conv_pkg.sv
// Shared types and geometry helpers for the depthwise-conv window sequencer.
// The output-size functions let parent and sequencer agree on the map geometry.
package dw_conv_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_ROW,
    ST_SWEEP,
    ST_DRAIN,
    ST_FINISH
  } state_e;

  function automatic int out_rows(input int fm_h, input int pad, input int stride);
    return (fm_h + 2 * pad - 3) / stride + 1;
  endfunction

  function automatic int out_cols(input int fm_w, input int pad, input int stride);
    return (fm_w + 2 * pad - 3) / stride + 1;
  endfunction

endpackage

// File: rtl/dw_conv_win_seq.sv
// Column sweep sequencer for a 3x3 sliding window over one feature map.
// It paces line-buffer reads, flags padding columns and tracks window coordinates.
module dw_conv_win_seq #(
  parameter int FM_W   = 32,
  parameter int FM_H   = 32,
  parameter int PAD    = 1,
  parameter int STRIDE = 1,
  parameter int CNT_W  = 6
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic             lb_row_rdy,
  output logic             col_shift,
  output logic             col_pad,
  output logic [CNT_W-1:0] lb_rd_col,
  output logic             win_valid,
  input  logic             win_ready,
  output logic [CNT_W-1:0] out_row,
  output logic [CNT_W-1:0] out_col,
  output logic             row_done,
  output logic             busy,
  output logic             done
);
  import dw_conv_pkg::*;

  localparam int N_ROWS = out_rows(FM_H, PAD, STRIDE);
  localparam logic [CNT_W-1:0] LAST_K      = CNT_W'(FM_W + 2 * PAD - 1);
  localparam logic [CNT_W-1:0] RIGHT_PAD_K = CNT_W'(FM_W + 1);
  localparam logic [CNT_W-1:0] LAST_ROW    = CNT_W'(N_ROWS - 1);
  localparam logic [CNT_W-1:0] PAD_C       = CNT_W'(PAD);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] k_q, k_d;
  logic [CNT_W-1:0] out_row_q, out_row_d;
  logic [CNT_W-1:0] out_col_q, out_col_d;
  logic             win_valid_q, win_valid_d;
  logic             row_done_q, row_done_d;

  logic             stall;
  logic             shift;
  logic             pad_col;
  logic             win_done;
  logic [CNT_W-1:0] k_m2;

  always_comb begin
    stall    = win_valid_q & ~win_ready;
    shift    = (state_q == ST_SWEEP) & ~stall;
    pad_col  = (PAD == 1) && ((k_q == '0) || (k_q == RIGHT_PAD_K));
    k_m2     = k_q - CNT_W'(2);
    // with stride 2 a window closes on every even k, i.e. (k-2) mod 2 == 0
    win_done = shift && (k_q >= CNT_W'(2)) && ((STRIDE == 1) || !k_q[0]);

    state_d     = state_q;
    k_d         = k_q;
    out_row_d   = out_row_q;
    out_col_d   = out_col_q;
    win_valid_d = win_valid_q & ~win_ready;
    row_done_d  = 1'b0;

    if (win_done) begin
      win_valid_d = 1'b1;
      out_col_d   = (STRIDE == 1) ? k_m2 : (k_m2 >> 1);
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_WAIT_ROW;
          k_d       = '0;
          out_row_d = '0;
          out_col_d = '0;
        end
      end
      ST_WAIT_ROW: begin
        if (lb_row_rdy) begin
          state_d = ST_SWEEP;
          k_d     = '0;
        end
      end
      ST_SWEEP: begin
        if (shift) begin
          if (k_q == LAST_K) begin
            k_d        = '0;
            row_done_d = 1'b1;
            state_d    = ST_DRAIN;
          end else begin
            k_d = k_q + CNT_W'(1);
          end
        end
      end
      ST_DRAIN: begin
        // the row's final window must leave before out_row may move on
        if (!win_valid_q || win_ready) begin
          if (out_row_q == LAST_ROW) begin
            state_d = ST_FINISH;
          end else begin
            out_row_d = out_row_q + CNT_W'(1);
            state_d   = ST_WAIT_ROW;
          end
        end
      end
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      k_q         <= '0;
      out_row_q   <= '0;
      out_col_q   <= '0;
      win_valid_q <= 1'b0;
      row_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      out_row_q   <= out_row_d;
      out_col_q   <= out_col_d;
      win_valid_q <= win_valid_d;
      row_done_q  <= row_done_d;
    end
  end

  always_comb begin
    col_shift = shift;
    col_pad   = shift & pad_col;
    lb_rd_col = pad_col ? '0 : (k_q - PAD_C);
    win_valid = win_valid_q;
    out_row   = out_row_q;
    out_col   = out_col_q;
    row_done  = row_done_q;
    busy      = (state_q == ST_WAIT_ROW) || (state_q == ST_SWEEP) || (state_q == ST_DRAIN);
    done      = (state_q == ST_FINISH);
  end

endmodule
